ibex_if_id_dummy_reg: RTL

IF-to-ID pipeline register stage that consumes the dummy-instruction generator's insert request and encoded dummy instruction. Each ID-accept cycle it selects between the prefetch buffer output and the dummy instruction, and registers the choice into the ID-stage instruction registers. A dummy marker travels with the instruction so ID/WB suppress its architectural effects. Fetch is back-pressured for the cycle in which a dummy is inserted.

---
 rtl/ibex_if_id_dummy_reg.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ibex_if_id_dummy_reg.sv
// IF/ID pipeline register with dummy-instruction insertion.
//
// Each cycle the ID stage accepts, this stage picks either the prefetch buffer output or the
// encoded dummy instruction. It registers that choice into the ID-stage instruction registers.
// A dummy carries the PC of the pending fetch and sets a marker bit, so that ID/WB can suppress
// its architectural effects. Fetch is back-pressured in any cycle where a dummy is inserted, so
// the fetched word stays in the prefetch buffer and program order is preserved.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   fetch_valid_i/rdata_i/addr_i/err_i   prefetch buffer output
//   fetch_ready_o                 fetched instruction consumed this cycle (combinational)
//   insert_dummy_instr_i          dummy generator insertion request
//   dummy_instr_data_i            encoded dummy instruction
//   id_in_ready_i                 ID stage accepts a new instruction
//   flush_i                       kill the stage (priority over load/insert)
//   instr_*_id_o, instr_fetch_err_o   registered ID-stage instruction
//   instr_new_id_o                one-cycle pulse after a valid load
//
// Optional (macro IBEX_DUMMY_INSTR_CNT_EN):
//   dummy_cnt_o      saturating count of inserted dummies
//   dummy_cnt_clr_i  synchronous clear of the counter (wins over increment)

module ibex_if_id_dummy_reg #(
  parameter bit DummyInstructions = 1'b1,
  parameter bit ResetAll          = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  input  logic [31:0] fetch_addr_i,
  input  logic        fetch_err_i,
  output logic        fetch_ready_o,
  input  logic        insert_dummy_instr_i,
  input  logic [31:0] dummy_instr_data_i,
  input  logic        id_in_ready_i,
  input  logic        flush_i,
`ifdef IBEX_DUMMY_INSTR_CNT_EN
  output logic [15:0] dummy_cnt_o,
  input  logic        dummy_cnt_clr_i,
`endif
  output logic        instr_valid_id_o,
  output logic [31:0] instr_rdata_id_o,
  output logic [31:0] instr_pc_id_o,
  output logic        instr_is_dummy_id_o,
  output logic        instr_fetch_err_o,
  output logic        instr_new_id_o
);

  logic        ins_dummy;
  logic        load;
  logic        valid_d, valid_q;
  logic        dummy_d, dummy_q;
  logic        new_d, new_q;
  logic        err_d, err_q;
  logic [31:0] rdata_d, rdata_q;
  logic [31:0] pc_d, pc_q;

  assign load          = id_in_ready_i & ~flush_i;
  assign ins_dummy     = DummyInstructions & insert_dummy_instr_i & load;
  assign fetch_ready_o = load & ~ins_dummy;

  always_comb begin
    valid_d = valid_q;
    dummy_d = dummy_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    pc_d    = pc_q;
    new_d   = 1'b0;
    if (flush_i) begin
      valid_d = 1'b0;
      dummy_d = 1'b0;
      err_d   = 1'b0;
    end else if (id_in_ready_i) begin
      if (ins_dummy) begin
        // Dummy borrows the PC of the pending fetch whether or not that fetch is valid.
        rdata_d = dummy_instr_data_i;
        pc_d    = fetch_addr_i;
        dummy_d = 1'b1;
        err_d   = 1'b0;
        valid_d = 1'b1;
        new_d   = 1'b1;
      end else if (fetch_valid_i) begin
        rdata_d = fetch_rdata_i;
        pc_d    = fetch_addr_i;
        err_d   = fetch_err_i;
        dummy_d = 1'b0;
        valid_d = 1'b1;
        new_d   = 1'b1;
      end else begin
        valid_d = 1'b0;
        dummy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      dummy_q <= 1'b0;
      new_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      dummy_q <= dummy_d;
      new_q   <= new_d;
    end
  end

  if (ResetAll) begin : gen_data_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        err_q   <= 1'b0;
        rdata_q <= 32'h0;
        pc_q    <= 32'h0;
      end else begin
        err_q   <= err_d;
        rdata_q <= rdata_d;
        pc_q    <= pc_d;
      end
    end
  end else begin : gen_data_norst
    always_ff @(posedge clk_i) begin
      err_q   <= err_d;
      rdata_q <= rdata_d;
      pc_q    <= pc_d;
    end
  end

`ifdef IBEX_DUMMY_INSTR_CNT_EN
  logic [15:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (dummy_cnt_clr_i) begin
      cnt_d = 16'h0;
    end else if (ins_dummy && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'h1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 16'h0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign dummy_cnt_o = cnt_q;
`endif

  assign instr_valid_id_o    = valid_q;
  assign instr_rdata_id_o    = rdata_q;
  assign instr_pc_id_o       = pc_q;
  assign instr_is_dummy_id_o = DummyInstructions & dummy_q;
  assign instr_fetch_err_o   = err_q;
  assign instr_new_id_o      = new_q;

endmodule
